// File: rtl/uart_tx_fifo_param_if.sv
// Write port of the parametrised UART transmitter: valid/ready word handshake.
interface uart_tx_fifo_param_if #(
  parameter int unsigned DATA_W = 8
);
  logic              WR_VALID;
  logic [DATA_W-1:0] WR_DATA;
  logic              WR_READY;

  modport master (
    output WR_VALID,
    output WR_DATA,
    input  WR_READY
  );

  modport slave (
    input  WR_VALID,
    input  WR_DATA,
    output WR_READY
  );
endinterface

// File: rtl/uart_tx_fifo_param.sv
// Parametrised UART transmitter: write FIFO feeding an LSB-first serialiser with optional
// parity and one or two stop bits, paced by an oversample tick, frames sent back-to-back.
module uart_tx_fifo_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned OVERSAMPLE = 8
) (
  input  logic                               internalclk,
  input  logic                               RESETN,
  input  logic                               TICK,
  uart_tx_fifo_param_if.slave                wr,
  input  logic [1:0]                         PARITY_MODE,
  input  logic                               STOP2,
  output logic                               TX,
  output logic                               BUSY,
  output logic                               DONE,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    FIFO_COUNT
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned TckW = $clog2(OVERSAMPLE);
  localparam int unsigned IdxW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage and pointers
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              push;
  logic              load;
  logic              fifo_nonempty;
  logic [DATA_W-1:0] head;

  // Serialiser state
  state_e            state_q, state_d;
  logic [TckW-1:0]   tick_q, tick_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic              par_en_q, par_en_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end;

  assign wr.WR_READY   = (count_q != CntW'(FIFO_DEPTH));
  assign push          = wr.WR_VALID && wr.WR_READY;
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem[rd_ptr_q];
  assign bit_end       = TICK && (tick_q == TckW'(OVERSAMPLE - 1));

  assign TX         = tx_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign FIFO_COUNT = count_q;

  always_ff @(posedge internalclk) begin
    if (push) begin
      mem[wr_ptr_q] <= wr.WR_DATA;
    end
  end

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge internalclk or posedge RESETN) begin
    if (RESETN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !load) begin
        count_q <= count_q + 1'b1;
      end else if (load && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    par_d    = par_q;
    par_en_d = par_en_q;
    stop2_d  = stop2_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load     = 1'b0;

    if (state_q != StIdle && TICK) begin
      tick_d = bit_end ? '0 : tick_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (fifo_nonempty) begin
          load = 1'b1;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      StData: begin
        if (bit_end) begin
          if (idx_q == IdxW'(DATA_W - 1)) begin
            idx_d = '0;
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = par_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        if (bit_end) begin
          // idx_q counts stop bits already sent
          if (stop2_q && idx_q == '0) begin
            idx_d = IdxW'(1);
          end else begin
            done_d = 1'b1;
            idx_d  = '0;
            if (fifo_nonempty) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Frame load overrides: config is latched here and held for the whole frame.
    if (load) begin
      state_d  = StStart;
      tick_d   = '0;
      idx_d    = '0;
      shift_d  = head;
      par_en_d = (PARITY_MODE == 2'b01) || (PARITY_MODE == 2'b10);
      par_d    = (^head) ^ (PARITY_MODE == 2'b10);
      stop2_d  = STOP2;
      tx_d     = 1'b0;
      busy_d   = 1'b1;
    end
  end

  always_ff @(posedge internalclk or posedge RESETN) begin
    if (RESETN) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      par_en_q <= par_en_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Bench for uart_tx_fifo_param: two instances (8-bit/x8 and 5-bit/x4), random ticks and words,
// frames checked bit-by-bit against frames built from the word and the config at load time.
module tb_uart_tx_fifo_param;

  logic       internalclk = 1'b0;
  logic       RESETN      = 1'b1;
  logic       TICK        = 1'b0;
  logic [1:0] pm8 = 2'b00, pm5 = 2'b00;
  logic       s28 = 1'b0,  s25 = 1'b0;
  logic       tx8, busy8, done8, tx5, busy5, done5;
  logic [2:0] cnt8, cnt5;

  int n_chk  = 0;
  int n_pass = 0;
  int exp8 [$];
  int exp5 [$];
  bit in_frame [0:1];

  uart_tx_fifo_param_if #(.DATA_W(8)) wr8 ();
  uart_tx_fifo_param_if #(.DATA_W(5)) wr5 ();

  uart_tx_fifo_param dut8 (
    .internalclk (internalclk),
    .RESETN      (RESETN),
    .TICK        (TICK),
    .wr          (wr8),
    .PARITY_MODE (pm8),
    .STOP2       (s28),
    .TX          (tx8),
    .BUSY        (busy8),
    .DONE        (done8),
    .FIFO_COUNT  (cnt8)
  );

  uart_tx_fifo_param #(
    .DATA_W     (5),
    .FIFO_DEPTH (4),
    .OVERSAMPLE (4)
  ) dut5 (
    .internalclk (internalclk),
    .RESETN      (RESETN),
    .TICK        (TICK),
    .wr          (wr5),
    .PARITY_MODE (pm5),
    .STOP2       (s25),
    .TX          (tx5),
    .BUSY        (busy5),
    .DONE        (done5),
    .FIFO_COUNT  (cnt5)
  );

  always #5 internalclk = ~internalclk;

  initial begin
    forever begin
      @(negedge internalclk);
      TICK = ($urandom_range(0, 2) == 0);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  function automatic int exp_size(input int sel);
    return (sel != 0) ? exp5.size() : exp8.size();
  endfunction

  function automatic int exp_pop(input int sel);
    if (sel != 0) return exp5.pop_front();
    return exp8.pop_front();
  endfunction

  function automatic void exp_push(input int sel, input int w);
    if (sel != 0) exp5.push_back(w);
    else exp8.push_back(w);
  endfunction

  function automatic logic tx_of(input int sel);   return (sel != 0) ? tx5 : tx8;     endfunction
  function automatic logic busy_of(input int sel); return (sel != 0) ? busy5 : busy8; endfunction
  function automatic logic done_of(input int sel); return (sel != 0) ? done5 : done8; endfunction
  function automatic int   cnt_of(input int sel);  return (sel != 0) ? int'(cnt5) : int'(cnt8); endfunction
  function automatic logic rdy_of(input int sel);
    return (sel != 0) ? wr5.WR_READY : wr8.WR_READY;
  endfunction
  function automatic logic [1:0] pm_of(input int sel); return (sel != 0) ? pm5 : pm8; endfunction
  function automatic logic s2_of(input int sel);       return (sel != 0) ? s25 : s28; endfunction

  // Offer one word; acceptance predicted from the model queue of words not yet started.
  task automatic wr_word(input int sel, input int data);
    bit acc;
    @(negedge internalclk);
    if (sel != 0) begin
      wr5.WR_VALID = 1'b1;
      wr5.WR_DATA  = data[4:0];
    end else begin
      wr8.WR_VALID = 1'b1;
      wr8.WR_DATA  = data[7:0];
    end
    acc = exp_size(sel) < 4;
    check_eq("wr_ready", rdy_of(sel), acc);
    check_eq("fifo_count", cnt_of(sel), exp_size(sel));
    @(posedge internalclk);
    if (acc) exp_push(sel, data & ((sel != 0) ? 31 : 255));
  endtask

  task automatic wr_end(input int sel);
    @(negedge internalclk);
    if (sel != 0) wr5.WR_VALID = 1'b0;
    else wr8.WR_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int sel);
    int n = 0;
    while (n < 20000 && !(exp_size(sel) == 0 && !in_frame[sel] && !busy_of(sel))) begin
      @(negedge internalclk);
      n++;
    end
    check_eq("idle_reached", n < 20000, 1);
  endtask

  // Frame monitor: expected frame built from the popped word and the config at the load edge.
  task automatic watch(input int sel);
    int   os, dw, nb, ticks, done_n, cyc, w;
    logic [1:0] pm;
    logic s2, tk, more;
    logic bits [0:15];
    os = (sel != 0) ? 4 : 8;
    dw = (sel != 0) ? 5 : 8;
    forever begin
      @(posedge internalclk);
      #1;
      if (RESETN || tx_of(sel)) continue;
      more = 1'b1;
      while (more) begin
        in_frame[sel] = 1'b1;
        check_eq("frame_expected", exp_size(sel) > 0, 1);
        if (exp_size(sel) == 0) break;
        w  = exp_pop(sel);
        pm = pm_of(sel);
        s2 = s2_of(sel);
        bits[0] = 1'b0;
        nb = 1;
        for (int i = 0; i < dw; i++) begin
          bits[nb] = w[i];
          nb++;
        end
        if (pm == 2'b01 || pm == 2'b10) begin
          bits[nb] = (($countones(w) % 2) == 1) ^ (pm == 2'b10);
          nb++;
        end
        bits[nb] = 1'b1;
        nb++;
        if (s2) begin
          bits[nb] = 1'b1;
          nb++;
        end
        check_eq("start_tx_busy", {tx_of(sel), busy_of(sel)}, 2'b01);
        ticks  = 0;
        done_n = 0;
        cyc    = 0;
        while (ticks < nb * os && cyc < 4000) begin
          @(posedge internalclk);
          tk = TICK;
          #1;
          cyc++;
          if (RESETN) break;
          if (tk) ticks++;
          if (done_of(sel)) done_n++;
          if (tk && ticks < nb * os && (ticks % os) == os / 2) begin
            check_eq("tx_bit", tx_of(sel), bits[ticks / os]);
            check_eq("busy_in_frame", busy_of(sel), 1);
          end
        end
        if (RESETN) begin
          more = 1'b0;
        end else begin
          check_eq("frame_ticks", ticks, nb * os);
          check_eq("done_pulses", done_n, 1);
          more = exp_size(sel) > 0;
          check_eq("frame_gap_tx", tx_of(sel), !more);
          check_eq("frame_gap_busy", busy_of(sel), more);
        end
      end
      in_frame[sel] = 1'b0;
    end
  endtask

  initial begin
    int k, cyc, bad, n;
    wr8.WR_VALID = 1'b0;
    wr8.WR_DATA  = '0;
    wr5.WR_VALID = 1'b0;
    wr5.WR_DATA  = '0;
    in_frame[0]  = 1'b0;
    in_frame[1]  = 1'b0;
    repeat (3) @(posedge internalclk);
    #1;
    check_eq("rst_tx", {tx8, tx5}, 2'b11);
    check_eq("rst_busy_done", {busy8, done8, busy5, done5}, 4'b0000);
    @(negedge internalclk);
    RESETN = 1'b0;
    fork
      watch(0);
      watch(1);
    join_none

    // Quiet line for 100 ticks with nothing written
    k = 0; cyc = 0; bad = 0;
    while (k < 100 && cyc < 5000) begin
      @(posedge internalclk);
      if (TICK) k++;
      #1;
      if (!tx8 || busy8 || done8 || !tx5 || busy5 || done5) bad++;
      cyc++;
    end
    check_eq("idle_activity", bad, 0);
    check_eq("idle_tx_busy8", {tx8, busy8}, 2'b10);
    check_eq("idle_ready_cnt8", {wr8.WR_READY, cnt8}, 4'b1000);
    check_eq("idle_ready_cnt5", {wr5.WR_READY, cnt5}, 4'b1000);

    // 0xA5, even parity, one stop
    pm8 = 2'b01; s28 = 1'b0;
    wr_word(0, 'hA5);
    wr_end(0);
    wait_idle(0);

    // 0x00, odd parity, two stops
    pm8 = 2'b10; s28 = 1'b1;
    wr_word(0, 'h00);
    wr_end(0);
    wait_idle(0);

    // Six back-to-back writes into a depth-4 FIFO
    pm8 = 2'b00; s28 = 1'b0;
    for (int i = 0; i < 6; i++) wr_word(0, 'h11 + i);
    wr_end(0);
    wait_idle(0);

    // Random bursts and configs
    for (int r = 0; r < 6; r++) begin
      wait_idle(0);
      pm8 = 2'($urandom_range(0, 3));
      s28 = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) wr_end(0);
        wr_word(0, $urandom_range(0, 255));
      end
      wr_end(0);
    end
    wait_idle(0);

    // 5-bit instance: 0x1F, no parity; config change mid-frame must not matter
    pm5 = 2'b00; s25 = 1'b0;
    wr_word(1, 'h1F);
    wr_end(1);
    cyc = 0;
    while (!in_frame[1] && cyc < 100) begin
      @(negedge internalclk);
      cyc++;
    end
    check_eq("w5_frame_started", in_frame[1], 1);
    repeat (10) @(negedge internalclk);
    pm5 = 2'b01;
    s25 = 1'b1;
    wait_idle(1);
    for (int r = 0; r < 4; r++) begin
      pm5 = 2'($urandom_range(0, 3));
      s25 = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) wr_word(1, $urandom_range(0, 31));
      wr_end(1);
      wait_idle(1);
    end

    // Reset in the middle of a data bit with two words queued
    pm8 = 2'b01; s28 = 1'b0;
    wr_word(0, 'h3C);
    wr_word(0, 'h5A);
    wr_word(0, 'h77);
    wr_end(0);
    k = 0; cyc = 0;
    while (k < 24 && cyc < 2000) begin
      @(posedge internalclk);
      if (TICK) k++;
      cyc++;
    end
    @(negedge internalclk);
    check_eq("pre_rst_count", cnt8, 2);
    check_eq("pre_rst_busy", busy8, 1);
    @(posedge internalclk);
    #3;
    RESETN = 1'b1;
    exp8.delete();
    #1;
    check_eq("rst_abort_tx_busy", {tx8, busy8, done8}, 3'b100);
    check_eq("rst_abort_ready_cnt", {wr8.WR_READY, cnt8}, 4'b1000);
    repeat (2) @(negedge internalclk);
    RESETN = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge internalclk);
      if (!tx8 || busy8) bad++;
    end
    check_eq("post_rst_quiet", bad, 0);
    check_eq("post_rst_cnt", cnt8, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
Name: uart_tx_fifo_param

Overview:
Parametrised UART transmitter, successor to the fixed 8-bit/8x-oversampled TX.
- Accepts words through a valid/ready write port into an internal FIFO.
- Serialises each word LSB-first with configurable parity (none/even/odd) and 1 or 2 stop bits.
- Paces bits from the shared baud-generator oversample tick and sends FIFO contents back-to-back with no idle gap.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
FIFO_DEPTH, 4, FIFO entries; power of two, >=2.
OVERSAMPLE, 8, TICK pulses per bit period; >=2.

Ports:
internalclk  in  1  block clock; all state updates on its rising edge.
RESETN  in  1  reset, asynchronous, active-high.
TICK  in  1  oversample enable; one internalclk cycle wide per tick.
WR_VALID  in  1  write request.
WR_DATA  in  DATA_W  word to enqueue.
WR_READY  out  1  FIFO not full. A write is accepted when WR_VALID & WR_READY.
PARITY_MODE  in  2  00 none, 01 even, 10 odd, 11 treated as none.
STOP2  in  1  0 = one stop bit, 1 = two stop bits.
TX  out  1  serial line; idles high.
BUSY  out  1  high from frame start to end of last stop bit.
DONE  out  1  one-cycle pulse at the end of each frame.
FIFO_COUNT  out  clog2(FIFO_DEPTH+1)  occupied entries.

Behaviour:
- Reset values (asserted asynchronously):
  - TX=1, BUSY=0, DONE=0, FIFO_COUNT=0, WR_READY=1.
  - FIFO pointers cleared; state=IDLE; tick counter=0; bit index=0.
  - Reset mid-frame aborts the frame and flushes the FIFO. TX returns high immediately.
- FIFO:
  - Circular buffer with wrap-around pointers.
  - WR_READY = (FIFO_COUNT != FIFO_DEPTH).
  - A write while full is not accepted and data is unchanged.
  - Pop occurs only in the frame-load cycle, and only if the FIFO was non-empty at the start of that cycle.
  - Simultaneous accepted write and pop: FIFO_COUNT unchanged.
  - A write into an empty FIFO is visible to the FSM the next cycle.
- Frame load:
  - Occurs in IDLE when FIFO_COUNT>0 (no TICK required).
  - Also occurs at the end of the final stop bit when FIFO_COUNT>0.
  - On load: pop head into shift register; latch PARITY_MODE and STOP2; compute parity.
    - Even parity = XOR of all DATA_W bits; odd parity = inverted XOR.
  - Clear tick counter, enter START, set TX=0 and BUSY=1 on that edge.
  - Config input changes mid-frame have no effect until the next load.
- Bit timing:
  - Tick counter increments on each internalclk edge with TICK=1.
  - A bit ends on the edge where TICK=1 and counter==OVERSAMPLE-1; the counter then wraps to 0.
  - Each bit therefore lasts exactly OVERSAMPLE ticks.
- States:
  - IDLE: TX=1, BUSY=0. Go to START on load.
  - START: TX=0 for one bit → DATA.
  - DATA: TX = shift[bit_index], bit_index 0..DATA_W-1. After bit DATA_W-1: go to PARITY if the latched mode is even/odd, else STOP.
  - PARITY: TX = parity bit for one bit → STOP.
  - STOP: TX=1 for 1 bit, or 2 bits if STOP2 is latched. At end: DONE=1 for exactly one cycle.
    - FIFO non-empty: load next word and enter START on the same edge; BUSY stays 1.
    - FIFO empty: go to IDLE and set BUSY=0.
- Frame length: 1 + DATA_W + (parity?1:0) + (STOP2?2:1) bits, times OVERSAMPLE ticks.
- TICK is ignored in IDLE. TX never glitches: it is a registered output.

Test Plan:
- Reset, then no writes for 100 ticks → TX=1, BUSY=0, WR_READY=1, FIFO_COUNT=0.
- Defaults, PARITY_MODE=01, STOP2=0, write 0xA5 → TX bits 0,1,0,1,0,0,1,0,1,0(parity),1, each 8 ticks. DONE pulses once. BUSY low after stop.
- PARITY_MODE=10, STOP2=1, write 0x00 → start, eight 0s, parity 1, two stop bits (16 ticks high). Total frame 12 bits.
- Write 6 words (0x11..0x16) back-to-back into depth 4 while TX is busy:
  - WR_READY drops when FIFO_COUNT=4; excess writes are not accepted.
  - Accepted words transmit in order with no idle between stop and start. DONE pulses once per frame.
- Assert RESETN mid-DATA of 0x3C with 2 words queued → TX=1 immediately, FIFO_COUNT=0. After release, no frame is sent.
- DATA_W=5, OVERSAMPLE=4, PARITY_MODE=00, write 5'h1F → 7-bit frame (0,1,1,1,1,1,1) of 28 ticks. Changing PARITY_MODE mid-frame does not alter the frame.
